binary_game_ctrl: RTL

Round sequencer for the "can you count binary" DIP-switch game.
- Picks a pseudo-random 8-bit target and presents it to the display logic.
- Times each round and judges the player's DIP-switch answer on a submit press.
- Keeps score and lives, and ends the game when the lives reach zero.
- Sits between the top-level pin wrapper (ui_in switches/buttons, uo_out/uio_out displays) and the display drivers.

---
 rtl/binary_game_pkg.sv | 40 ++++
 rtl/btn_sync_edge.sv | 33 +++
 rtl/binary_game_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/binary_game_pkg.sv
// Shared types and constants for the binary-counting game sequencer.
package binary_game_pkg;

    // Datapath widths
    localparam int TGT_W   = 8;
    localparam int LIVES_W = 4;
    localparam int TIMER_W = 16;

    // Round sequencer states; the codes are visible on state_o
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_CORRECT = 3'd2,
        ST_WRONG   = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    // Fibonacci taps at bits 7,5,4,3 (maximal length, never reaches zero)
    localparam logic [TGT_W-1:0] LFSR_TAPS         = 8'hB8;
    localparam logic [TGT_W-1:0] LFSR_SEED_DEFAULT = 8'hA5;

    // One left shift of the target LFSR; feedback enters at bit 0
    function automatic logic [TGT_W-1:0] lfsr_next(input logic [TGT_W-1:0] q);
        logic fb;
        fb = ^(q & LFSR_TAPS);
        return {q[TGT_W-2:0], fb};
    endfunction

    // Score increment that sticks at the all-ones value
    function automatic logic [TGT_W-1:0] sat_inc(input logic [TGT_W-1:0] v);
        logic [TGT_W-1:0] r;
        if (v == {TGT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(TGT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw push button followed by a rising-edge
// detector. The registered one-cycle pulse appears three clocks after the
// raw rise; held levels produce no further pulses.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Metastability chain, edge-history flop and registered edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/binary_game_ctrl.sv
// Round sequencer for the "can you count binary" DIP-switch game: picks an
// LFSR target, times the round, judges the submitted switches and tracks
// score and lives until the game is over.
module binary_game_ctrl
    import binary_game_pkg::*;
#(
    parameter logic [TIMER_W-1:0] ROUND_CYCLES  = 16'd50000,
    parameter logic [TIMER_W-1:0] RESULT_CYCLES = 16'd10000,
    parameter logic [LIVES_W-1:0] LIVES         = 4'd3,
    parameter logic [TGT_W-1:0]   LFSR_SEED     = LFSR_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               submit_i,
    input  logic [TGT_W-1:0]   switches_i,
    output logic [TGT_W-1:0]   target_o,
    output logic [TGT_W-1:0]   score_o,
    output logic [LIVES_W-1:0] lives_o,
    output logic [2:0]         state_o,
    output logic               correct_o,
    output logic               wrong_o,
    output logic               timeout_o,
    output logic [TIMER_W-1:0] time_left_o
);

    // Button pulses
    logic start_pulse_s;
    logic submit_pulse_s;

    // State and datapath registers
    state_e             state_q,     state_d;
    logic [TGT_W-1:0]   lfsr_q;
    logic [TGT_W-1:0]   target_q,    target_d;
    logic [TIMER_W-1:0] time_left_q, time_left_d;
    logic [TIMER_W-1:0] hold_q,      hold_d;
    logic [TGT_W-1:0]   score_q,     score_d;
    logic [LIVES_W-1:0] lives_q,     lives_d;
    logic               timeout_q,   timeout_d;
    logic               correct_q,   correct_d;
    logic               wrong_q,     wrong_d;

    // Decoded actions shared by several states
    logic new_round_s;
    logic start_game_s;

    btn_sync_edge u_start_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (start_i),
        .pulse_o (start_pulse_s)
    );

    btn_sync_edge u_submit_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (submit_i),
        .pulse_o (submit_pulse_s)
    );

    // Free-running target generator, advancing in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // Next-state and datapath decisions for the round sequencer
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        time_left_d  = time_left_q;
        hold_d       = hold_q;
        score_d      = score_q;
        lives_d      = lives_q;
        timeout_d    = timeout_q;
        new_round_s  = 1'b0;
        start_game_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                // Submit pulses are meaningless here and simply fall away
                if (start_pulse_s) begin
                    start_game_s = 1'b1;
                    new_round_s  = 1'b1;
                end else begin
                    target_d    = {TGT_W{1'b0}};
                    time_left_d = {TIMER_W{1'b0}};
                end
            end

            ST_PLAY: begin
                // A submit on the final cycle outranks the timeout
                if (submit_pulse_s) begin
                    time_left_d = {TIMER_W{1'b0}};
                    hold_d      = RESULT_CYCLES - 16'd1;
                    if (switches_i == target_q) begin
                        state_d = ST_CORRECT;
                        score_d = sat_inc(score_q);
                    end else begin
                        state_d = ST_WRONG;
                        if (lives_q != {LIVES_W{1'b0}}) begin
                            lives_d = lives_q - 4'd1;
                        end else begin
                            lives_d = lives_q;
                        end
                    end
                end else if (time_left_q == {TIMER_W{1'b0}}) begin
                    state_d   = ST_WRONG;
                    timeout_d = 1'b1;
                    hold_d    = RESULT_CYCLES - 16'd1;
                    if (lives_q != {LIVES_W{1'b0}}) begin
                        lives_d = lives_q - 4'd1;
                    end else begin
                        lives_d = lives_q;
                    end
                end else begin
                    time_left_d = time_left_q - 16'd1;
                end
            end

            ST_CORRECT: begin
                // Pulses arriving during the hold are dropped
                if (hold_q == {TIMER_W{1'b0}}) begin
                    new_round_s = 1'b1;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end

            ST_WRONG: begin
                if (hold_q == {TIMER_W{1'b0}}) begin
                    timeout_d = 1'b0;
                    if (lives_q == {LIVES_W{1'b0}}) begin
                        state_d  = ST_OVER;
                        target_d = {TGT_W{1'b0}};
                    end else begin
                        new_round_s = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                target_d    = {TGT_W{1'b0}};
                time_left_d = {TIMER_W{1'b0}};
                hold_d      = {TIMER_W{1'b0}};
                timeout_d   = 1'b0;
            end
        endcase

        if (start_game_s) begin
            score_d = {TGT_W{1'b0}};
            lives_d = LIVES;
        end else begin
            score_d = score_d;
        end

        if (new_round_s) begin
            state_d     = ST_PLAY;
            target_d    = lfsr_q;
            time_left_d = ROUND_CYCLES - 16'd1;
            hold_d      = {TIMER_W{1'b0}};
        end else begin
            hold_d = hold_d;
        end

        // Result flags are registered alongside the state they describe
        correct_d = (state_d == ST_CORRECT);
        wrong_d   = (state_d == ST_WRONG);
    end

    // Sequencer state and all output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_q    <= {TGT_W{1'b0}};
            time_left_q <= {TIMER_W{1'b0}};
            hold_q      <= {TIMER_W{1'b0}};
            score_q     <= {TGT_W{1'b0}};
            lives_q     <= LIVES;
            timeout_q   <= 1'b0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            time_left_q <= time_left_d;
            hold_q      <= hold_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            timeout_q   <= timeout_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
        end
    end

    assign target_o    = target_q;
    assign score_o     = score_q;
    assign lives_o     = lives_q;
    assign state_o     = state_q;
    assign correct_o   = correct_q;
    assign wrong_o     = wrong_q;
    assign timeout_o   = timeout_q;
    assign time_left_o = time_left_q;

endmodule
